iq_flush_return_sequencer: RTL and testbench
============================================

// Module: iq_flush_return_sequencer
// PURPOSE
//  Sequences selective flush of the issue queue and returns freed entry indices to the IQ free
//  list over RET_WIDTH dedicated ports, ceil(ENTRY_NUM/RET_WIDTH) cycles per pass.
//  Also fills the free list with every index after reset. Sits beside the scheduler/IQ free
//  list; driven by the recovery manager, stalls dispatch while busy.
// PARAMETERS
//  ENTRY_NUM     ISSUE_QUEUE_ENTRY_NUM (16)           issue queue entries
//  RET_WIDTH     ISSUE_QUEUE_RETURN_INDEX_WIDTH (2)   free-list return ports
//  AL_ENTRY_NUM  ACTIVE_LIST_ENTRY_NUM (64)           active list entries (age arithmetic)
// PORTS
//  clk             in   1                       clock
//  rst_n           in   1                       asynchronous active-low reset
//  flushReq        in   1                       start selective flush (1-cycle pulse)
//  flushInclRecov  in   1                       1: flush op at recoveryPtr too (REFETCH_THIS)
//  recoveryPtr     in   AL_W                    active-list ptr of recovery point
//  alHeadPtr       in   AL_W                    active-list head, for age conversion
//  entryValid      in   ENTRY_NUM               IQ valid bits
//  entryAlPtr      in   ENTRY_NUM x AL_W        activeListPtr of each IQ entry
//  invalidateMask  out  ENTRY_NUM               entries the IQ must clear this cycle
//  returnValid     out  RET_WIDTH               per-port index valid to free list
//  returnIndex     out  RET_WIDTH x IQ_W        IssueQueueIndexPath per port
//  busy            out  1                       dispatch/issue stall
//  done            out  1                       1-cycle pulse on final return cycle
// BEHAVIOUR
//  - States: INIT, IDLE, FLUSH. Regs: state, slotCnt (IQ_RET_CYCLE_W bits), pendMask[ENTRY_NUM].
//  - Reset (async, rst_n=0): state=INIT, slotCnt=0, pendMask=all-ones; outputs: busy=1,
//    returnValid=0, invalidateMask=0, done=0. Reset mid-pass aborts it immediately.
//  - Age: age(p)=p+(p<alHeadPtr ? AL_ENTRY_NUM:0), AL_W+1 bits, unsigned compare. Entry i
//    selected iff entryValid[i] && (age(entryAlPtr[i])>age(recoveryPtr) ||
//    (== && flushInclRecov)).
//  - Slot k (k=slotCnt) covers entries k*RET_WIDTH+j, j<RET_WIDTH. Port j:
//    returnValid[j]=pendMask[idx]; returnIndex[j]=idx. idx>=ENTRY_NUM -> returnValid[j]=0.
//    Returned bits cleared in pendMask same edge.
//  - INIT: returns all indices, slot 0..LAST (LAST=ceil(ENTRY_NUM/RET_WIDTH)-1), busy=1;
//    flushReq ignored. At LAST: done=1, -> IDLE.
//  - IDLE: busy=0, returnValid=0. flushReq sampled at T: edge T loads pendMask=selected mask,
//    slotCnt=0, -> FLUSH. At T+1: invalidateMask=loaded mask (one cycle only), busy=1,
//    slot 0 returned.
//  - FLUSH: one slot per cycle; at slotCnt==LAST done=1, -> IDLE next edge. Pass = LAST+1 cycles;
//    empty mask still runs full pass (fixed latency).
//  - flushReq in FLUSH (incl. LAST): new selected mask ORed into pendMask (after clearing
//    current slot), slotCnt=0, invalidateMask=new mask next cycle, done suppressed. No index is
//    returned twice: previously selected entries are already invalid in IQ.
//  - busy is registered-state-derived (no combinational path from flushReq).
// STRUCTURE
//  - SchedulerTypes additions: IQ_FlushSeqState enum {INIT,IDLE,FLUSH};
//    IQ_RET_LAST_SLOT = ISSUE_QUEUE_RETURN_INDEX_CYCLE-1; reuse ActiveListPtrToAge,
//    ISSUE_QUEUE_RETURN_INDEX_CYCLE_BIT_SIZE.
//  - Sub-module iq_flush_mask_gen: combinational per-entry age compare -> selected mask.
//  - Top: FSM, slot counter, pendMask, output muxing.
// TESTING  (ENTRY_NUM=16, RET_WIDTH=2, AL_ENTRY_NUM=64)
//  - Reset release -> 8 cycles returning {0,1},{2,3}..{14,15}, busy=1, done at cycle 8, then IDLE.
//  - head=10, recov=20, incl=0, entries 3,7 ptr 25, entry 5 ptr 20 -> invalidateMask=0x0088;
//    returns 3 (slot1), 7 (slot3); busy 8 cycles.
//  - Wrap: head=60, recov=62, entry 0 ptr 2, entry 1 ptr 61, incl=1 -> only entry 0 flushed.
//  - Same setup, incl=1, entry 5 ptr 20 -> 5 also flushed (mask 0x00A8).
//  - Second flushReq at slot 5 selecting entry 12 -> slotCnt restarts 0, 12 returned once,
//    earlier indices not re-returned, single done at end.
//  - rst_n low at slot 3 of FLUSH -> returnValid=0 immediately; full INIT pass follows release.

Source files
------------

// File: rtl/iq_flush_return_sequencer_pkg.sv
// Shared scheduler types for the issue-queue flush/return sequencer.
//   - Default sizing of the issue queue, its free-list return ports and the
//     active list.
//   - Return-pass length and slot-counter width helpers.
//   - IQ_FlushSeqState: sequencer FSM states.
package iq_flush_return_sequencer_pkg;

  localparam int ISSUE_QUEUE_ENTRY_NUM          = 16;
  localparam int ISSUE_QUEUE_RETURN_INDEX_WIDTH = 2;
  localparam int ACTIVE_LIST_ENTRY_NUM          = 64;

  // Cycles needed to walk every IQ index through the return ports.
  function automatic int RetCycles(input int entries, input int width);
    return (entries + width - 1) / width;
  endfunction

  // Counter/index width that stays at least one bit for degenerate sizes.
  function automatic int CntBits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ISSUE_QUEUE_RETURN_INDEX_CYCLE =
    RetCycles(ISSUE_QUEUE_ENTRY_NUM, ISSUE_QUEUE_RETURN_INDEX_WIDTH);
  localparam int ISSUE_QUEUE_RETURN_INDEX_CYCLE_BIT_SIZE =
    CntBits(ISSUE_QUEUE_RETURN_INDEX_CYCLE);
  localparam int IQ_RET_LAST_SLOT = ISSUE_QUEUE_RETURN_INDEX_CYCLE - 1;

  typedef enum logic [1:0] {
    IQ_FS_INIT  = 2'd0,
    IQ_FS_IDLE  = 2'd1,
    IQ_FS_FLUSH = 2'd2
  } IQ_FlushSeqState;

endpackage

// File: rtl/iq_flush_return_sequencer_mask_gen.sv
// iq_flush_mask_gen: combinational selection of the IQ entries younger than
// the recovery point (optionally including it).
//   recoveryPtr    in  active-list pointer of the recovery point
//   alHeadPtr      in  active-list head, used to turn pointers into ages
//   flushInclRecov in  also select the op sitting at recoveryPtr
//   entryValid     in  IQ valid bits
//   entryAlPtr     in  active-list pointer of each IQ entry
//   selMask        out entries to flush
module iq_flush_mask_gen
  import iq_flush_return_sequencer_pkg::*;
#(
  parameter int ENTRY_NUM    = ISSUE_QUEUE_ENTRY_NUM,
  parameter int AL_ENTRY_NUM = ACTIVE_LIST_ENTRY_NUM,
  localparam int AL_W        = CntBits(AL_ENTRY_NUM)
) (
  input  logic [AL_W-1:0]                recoveryPtr,
  input  logic [AL_W-1:0]                alHeadPtr,
  input  logic                           flushInclRecov,
  input  logic [ENTRY_NUM-1:0]           entryValid,
  input  logic [ENTRY_NUM-1:0][AL_W-1:0] entryAlPtr,
  output logic [ENTRY_NUM-1:0]           selMask
);

  localparam logic [AL_W:0] AL_SPAN = AL_ENTRY_NUM[AL_W:0];

  // Pointers that have wrapped past the head are the youngest, so they are
  // lifted by one full active-list span to make ages monotonic.
  function automatic logic [AL_W:0] ActiveListPtrToAge(input logic [AL_W-1:0] ptr,
                                                       input logic [AL_W-1:0] head);
    logic [AL_W:0] ext;
    ext = {1'b0, ptr};
    return (ptr < head) ? ext + AL_SPAN : ext;
  endfunction

  logic [AL_W:0] recovAge;
  logic [AL_W:0] entryAge;

  always_comb begin
    selMask  = '0;
    entryAge = '0;
    recovAge = ActiveListPtrToAge(recoveryPtr, alHeadPtr);
    for (int i = 0; i < ENTRY_NUM; i++) begin
      entryAge   = ActiveListPtrToAge(entryAlPtr[i], alHeadPtr);
      selMask[i] = entryValid[i] &&
                   ((entryAge > recovAge) || ((entryAge == recovAge) && flushInclRecov));
    end
  end

endmodule

// File: rtl/iq_flush_return_sequencer.sv
// iq_flush_return_sequencer: fills the IQ free list with every index after
// reset, and on a selective flush invalidates the younger IQ entries and
// returns their indices over RET_WIDTH ports, one slot of RET_WIDTH indices
// per cycle, in a fixed-length pass.
//   clk, rst_n      clock, asynchronous active-low reset
//   flushReq        start (or extend) a selective flush, 1-cycle pulse
//   flushInclRecov  also flush the op at recoveryPtr
//   recoveryPtr     active-list pointer of the recovery point
//   alHeadPtr       active-list head for age conversion
//   entryValid      IQ valid bits
//   entryAlPtr      active-list pointer per IQ entry
//   invalidateMask  entries the IQ clears this cycle
//   returnValid     per-port free-list return valid
//   returnIndex     per-port returned IQ index
//   busy            stall dispatch/issue while a pass is running
//   done            pulse on the final return cycle of a pass
//   dbgState        current sequencer state
// Free-list handshake: returnValid[j] is a valid-only push; the free list
// always accepts, so an index is consumed on every clock edge where
// returnValid[j] is high and is never presented again.
module iq_flush_return_sequencer
  import iq_flush_return_sequencer_pkg::*;
#(
  parameter int ENTRY_NUM    = ISSUE_QUEUE_ENTRY_NUM,
  parameter int RET_WIDTH    = ISSUE_QUEUE_RETURN_INDEX_WIDTH,
  parameter int AL_ENTRY_NUM = ACTIVE_LIST_ENTRY_NUM,
  localparam int AL_W        = CntBits(AL_ENTRY_NUM),
  localparam int IQ_W        = CntBits(ENTRY_NUM),
  localparam int RET_CYCLE   = RetCycles(ENTRY_NUM, RET_WIDTH),
  localparam int CNT_W       = CntBits(RET_CYCLE)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flushReq,
  input  logic                           flushInclRecov,
  input  logic [AL_W-1:0]                recoveryPtr,
  input  logic [AL_W-1:0]                alHeadPtr,
  input  logic [ENTRY_NUM-1:0]           entryValid,
  input  logic [ENTRY_NUM-1:0][AL_W-1:0] entryAlPtr,
  output logic [ENTRY_NUM-1:0]           invalidateMask,
  output logic [RET_WIDTH-1:0]           returnValid,
  output logic [RET_WIDTH-1:0][IQ_W-1:0] returnIndex,
  output logic                           busy,
  output logic                           done,
  output IQ_FlushSeqState                dbgState
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RET_CYCLE - 1);
  localparam logic [CNT_W-1:0] SLOT_ONE  = CNT_W'(1);

  IQ_FlushSeqState        state, stateNext;
  logic [CNT_W-1:0]       slotCnt, slotCntNext;
  logic [ENTRY_NUM-1:0]   pendMask, pendMaskNext;
  logic [ENTRY_NUM-1:0]   invMask, invMaskNext;

  logic [ENTRY_NUM-1:0]   selMask;
  logic [ENTRY_NUM-1:0]   slotMask;
  logic [RET_WIDTH-1:0]   slotValid;
  int                     idx;
  logic                   active;
  logic                   lastSlot;
  logic                   flushRestart;

  iq_flush_mask_gen #(
    .ENTRY_NUM    (ENTRY_NUM),
    .AL_ENTRY_NUM (AL_ENTRY_NUM)
  ) u_mask_gen (
    .recoveryPtr    (recoveryPtr),
    .alHeadPtr      (alHeadPtr),
    .flushInclRecov (flushInclRecov),
    .entryValid     (entryValid),
    .entryAlPtr     (entryAlPtr),
    .selMask        (selMask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IQ_FS_INIT;
      slotCnt  <= '0;
      pendMask <= '1;
      invMask  <= '0;
    end else begin
      state    <= stateNext;
      slotCnt  <= slotCntNext;
      pendMask <= pendMaskNext;
      invMask  <= invMaskNext;
    end
  end

  always_comb begin
    slotMask     = '0;
    slotValid    = '0;
    returnIndex  = '0;
    idx          = 0;
    stateNext    = state;
    slotCntNext  = slotCnt;
    pendMaskNext = pendMask;
    invMaskNext  = '0;

    // Indices covered by the current slot; the tail slot may run past the
    // last entry when ENTRY_NUM is not a multiple of RET_WIDTH.
    for (int j = 0; j < RET_WIDTH; j++) begin
      idx            = int'(slotCnt) * RET_WIDTH + j;
      returnIndex[j] = idx[IQ_W-1:0];
      if (idx < ENTRY_NUM) begin
        slotMask[idx[IQ_W-1:0]] = 1'b1;
        slotValid[j]            = pendMask[idx[IQ_W-1:0]];
      end
    end

    active       = (state != IQ_FS_IDLE);
    lastSlot     = (slotCnt == LAST_SLOT);
    flushRestart = (state == IQ_FS_FLUSH) && flushReq;

    case (state)
      IQ_FS_INIT: begin
        pendMaskNext = pendMask & ~slotMask;
        if (lastSlot) begin
          stateNext   = IQ_FS_IDLE;
          slotCntNext = '0;
        end else begin
          slotCntNext = slotCnt + SLOT_ONE;
        end
      end
      IQ_FS_IDLE: begin
        if (flushReq) begin
          stateNext    = IQ_FS_FLUSH;
          slotCntNext  = '0;
          pendMaskNext = selMask;
          invMaskNext  = selMask;
        end
      end
      IQ_FS_FLUSH: begin
        if (flushReq) begin
          // Newly selected entries are still valid in the IQ, so none of them
          // can already be pending; restarting the walk covers them all.
          slotCntNext  = '0;
          pendMaskNext = (pendMask & ~slotMask) | selMask;
          invMaskNext  = selMask;
        end else begin
          pendMaskNext = pendMask & ~slotMask;
          if (lastSlot) begin
            stateNext   = IQ_FS_IDLE;
            slotCntNext = '0;
          end else begin
            slotCntNext = slotCnt + SLOT_ONE;
          end
        end
      end
      default: begin
        stateNext    = IQ_FS_INIT;
        slotCntNext  = '0;
        pendMaskNext = '1;
      end
    endcase
  end

  // Returns and done are held quiet while reset is asserted, even though the
  // reset state is INIT with every index pending.
  assign returnValid    = slotValid & {RET_WIDTH{active && rst_n}};
  assign done           = rst_n && active && lastSlot && !flushRestart;
  assign busy           = active;
  assign invalidateMask = invMask;
  assign dbgState       = state;

endmodule

// File: tb/tb_iq_flush_return_sequencer.sv
// Bench for iq_flush_return_sequencer (16 entries, 2 return ports, 64-entry
// active list). A behavioural model tracks the pending index set and the pass
// position; a compare process checks every output each cycle, and directed
// scenarios check returned-index sequences and invalidate masks against
// hand-computed literals.
module tb_iq_flush_return_sequencer;
  import iq_flush_return_sequencer_pkg::*;

  localparam int EN  = 16;
  localparam int RW  = 2;
  localparam int ALN = 64;
  localparam int NSLOT = 8;

  logic                clk;
  logic                rst_n;
  logic                flushReq;
  logic                flushInclRecov;
  logic [5:0]          recoveryPtr;
  logic [5:0]          alHeadPtr;
  logic [EN-1:0]       entryValid;
  logic [EN-1:0][5:0]  entryAlPtr;
  logic [EN-1:0]       invalidateMask;
  logic [RW-1:0]       returnValid;
  logic [RW-1:0][3:0]  returnIndex;
  logic                busy;
  logic                done;
  IQ_FlushSeqState     dbgState;

  iq_flush_return_sequencer #(
    .ENTRY_NUM    (EN),
    .RET_WIDTH    (RW),
    .AL_ENTRY_NUM (ALN)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flushReq       (flushReq),
    .flushInclRecov (flushInclRecov),
    .recoveryPtr    (recoveryPtr),
    .alHeadPtr      (alHeadPtr),
    .entryValid     (entryValid),
    .entryAlPtr     (entryAlPtr),
    .invalidateMask (invalidateMask),
    .returnValid    (returnValid),
    .returnIndex    (returnIndex),
    .busy           (busy),
    .done           (done),
    .dbgState       (dbgState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and checker ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = filling free list after reset, 1 = idle, 2 = flush pass
  int          mMode = 0;
  int          mSlot = 0;
  bit          mPend [EN];
  logic [EN-1:0] mInv = '0;

  function automatic int ageOf(input int p, input int head);
    return p + ((p < head) ? ALN : 0);
  endfunction

  function automatic logic [EN-1:0] modelSelect();
    logic [EN-1:0] s;
    int ra;
    s  = '0;
    ra = ageOf(int'(recoveryPtr), int'(alHeadPtr));
    for (int i = 0; i < EN; i++) begin
      int ea;
      ea = ageOf(int'(entryAlPtr[i]), int'(alHeadPtr));
      if (entryValid[i] && (ea > ra || (ea == ra && flushInclRecov))) s[i] = 1'b1;
    end
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mMode = 0;
      mSlot = 0;
      for (int i = 0; i < EN; i++) mPend[i] = 1'b1;
      mInv  = '0;
    end else begin
      logic [EN-1:0] sel;
      sel  = modelSelect();
      mInv = '0;
      if (mMode != 1) begin
        for (int j = 0; j < RW; j++) if (mSlot * RW + j < EN) mPend[mSlot * RW + j] = 1'b0;
      end
      if (mMode == 0) begin
        if (mSlot == NSLOT - 1) begin mMode = 1; mSlot = 0; end
        else mSlot++;
      end else if (mMode == 1) begin
        if (flushReq) begin
          for (int i = 0; i < EN; i++) mPend[i] = sel[i];
          mSlot = 0; mMode = 2; mInv = sel;
        end
      end else begin
        if (flushReq) begin
          for (int i = 0; i < EN; i++) if (sel[i]) mPend[i] = 1'b1;
          mSlot = 0; mInv = sel;
        end else if (mSlot == NSLOT - 1) begin
          mMode = 1; mSlot = 0;
        end else begin
          mSlot++;
        end
      end
    end
  end

  // ---------------- scoreboard / recording ----------------
  logic [3:0]    got_q [$];
  logic [3:0]    exp_q [$];
  logic [EN-1:0] inv_q [$];
  int doneCnt = 0;
  int busyCnt = 0;

  always @(negedge clk) begin
    logic [RW-1:0] eRv;
    logic          eDone;
    #2;
    eRv = '0;
    for (int j = 0; j < RW; j++)
      eRv[j] = rst_n && (mMode != 1) && (mSlot * RW + j < EN) && mPend[mSlot * RW + j];
    eDone = rst_n && (mMode != 1) && (mSlot == NSLOT - 1) && !(mMode == 2 && flushReq);
    chk("busy", 32'(busy), 32'(mMode != 1));
    chk("returnValid", 32'(returnValid), 32'(eRv));
    for (int j = 0; j < RW; j++)
      if (eRv[j]) chk("returnIndex", 32'(returnIndex[j]), 32'(mSlot * RW + j));
    chk("done", 32'(done), 32'(eDone));
    chk("invalidateMask", 32'(invalidateMask), 32'(mInv));
    if (rst_n) begin
      for (int j = 0; j < RW; j++) if (returnValid[j]) got_q.push_back(returnIndex[j]);
      if (done) doneCnt++;
      if (busy) busyCnt++;
      if (invalidateMask != '0) inv_q.push_back(invalidateMask);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clearRec();
    got_q.delete();
    exp_q.delete();
    inv_q.delete();
    doneCnt = 0;
    busyCnt = 0;
  endtask

  task automatic waitIdle(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      #3;
      if (!busy) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: busy still high after %0d cycles", name, budget);
    end
  endtask

  task automatic pulseFlush();
    @(negedge clk);
    flushReq = 1'b1;
    @(negedge clk);
    flushReq = 1'b0;
  endtask

  task automatic setupA(input logic incl);
    alHeadPtr      = 6'd10;
    recoveryPtr    = 6'd20;
    flushInclRecov = incl;
    entryValid     = '0;
    entryAlPtr     = '0;
    entryValid[3] = 1'b1; entryAlPtr[3] = 6'd25;
    entryValid[5] = 1'b1; entryAlPtr[5] = 6'd20;
    entryValid[7] = 1'b1; entryAlPtr[7] = 6'd25;
    entryValid[9] = 1'b1; entryAlPtr[9] = 6'd15;
  endtask

  task automatic checkRet(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({name, "_idx"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic expAll();
    exp_q.delete();
    for (int i = 0; i < EN; i++) exp_q.push_back(4'(i));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst_n          = 1'b0;
    flushReq       = 1'b0;
    flushInclRecov = 1'b0;
    recoveryPtr    = '0;
    alHeadPtr      = '0;
    entryValid     = '0;
    entryAlPtr     = '0;

    // Reset, then the free-list fill pass.
    repeat (3) @(negedge clk);
    #3;
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_returnValid", 32'(returnValid), 32'd0);
    clearRec();
    @(negedge clk);
    rst_n = 1'b1;
    waitIdle(30, "init_pass");
    expAll();
    checkRet("init_ret");
    chk("init_done_cnt", 32'(doneCnt), 32'd1);
    chk("init_busy_cycles", 32'(busyCnt), 32'd8);
    chk("idle_state", 32'(dbgState), 32'(IQ_FS_IDLE));

    // Basic selective flush: entries 3 and 7 are younger than recovery.
    clearRec();
    setupA(1'b0);
    pulseFlush();
    waitIdle(30, "flush_a");
    exp_q = '{4'd3, 4'd7};
    checkRet("flush_a_ret");
    chk("flush_a_inv_cnt", 32'(inv_q.size()), 32'd1);
    if (inv_q.size() > 0) chk("flush_a_inv", 32'(inv_q[0]), 32'h0088);
    chk("flush_a_busy_cycles", 32'(busyCnt), 32'd8);
    chk("flush_a_done_cnt", 32'(doneCnt), 32'd1);

    // Wrapped pointers: entry 0 (ptr 2) is young, entry 1 (ptr 61) is old.
    clearRec();
    alHeadPtr      = 6'd60;
    recoveryPtr    = 6'd62;
    flushInclRecov = 1'b1;
    entryValid     = 16'h0003;
    entryAlPtr     = '0;
    entryAlPtr[0]  = 6'd2;
    entryAlPtr[1]  = 6'd61;
    pulseFlush();
    waitIdle(30, "flush_wrap");
    exp_q = '{4'd0};
    checkRet("flush_wrap_ret");
    if (inv_q.size() > 0) chk("flush_wrap_inv", 32'(inv_q[0]), 32'h0001);
    else chk("flush_wrap_inv_cnt", 32'(inv_q.size()), 32'd1);

    // Including the recovery op pulls in entry 5 (ptr == recoveryPtr).
    clearRec();
    setupA(1'b1);
    pulseFlush();
    waitIdle(30, "flush_incl");
    exp_q = '{4'd3, 4'd5, 4'd7};
    checkRet("flush_incl_ret");
    if (inv_q.size() > 0) chk("flush_incl_inv", 32'(inv_q[0]), 32'h00A8);
    else chk("flush_incl_inv_cnt", 32'(inv_q.size()), 32'd1);

    // Second flush at slot 5 selecting entry 12: the pass restarts.
    clearRec();
    setupA(1'b0);
    pulseFlush();
    repeat (5) @(negedge clk);
    entryValid[3]  = 1'b0;
    entryValid[7]  = 1'b0;
    entryValid[12] = 1'b1;
    entryAlPtr[12] = 6'd30;
    flushReq = 1'b1;
    @(negedge clk);
    flushReq = 1'b0;
    waitIdle(30, "flush_re");
    exp_q = '{4'd3, 4'd7, 4'd12};
    checkRet("flush_re_ret");
    chk("flush_re_inv_cnt", 32'(inv_q.size()), 32'd2);
    if (inv_q.size() > 1) chk("flush_re_inv2", 32'(inv_q[1]), 32'h1000);
    chk("flush_re_done_cnt", 32'(doneCnt), 32'd1);
    chk("flush_re_busy_cycles", 32'(busyCnt), 32'd14);

    // Reset in the middle of a pass, then a complete fill pass.
    clearRec();
    setupA(1'b0);
    pulseFlush();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #3;
    chk("midrst_returnValid", 32'(returnValid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_inv", 32'(invalidateMask), 32'd0);
    exp_q = '{4'd3};
    checkRet("midrst_partial");
    entryValid = '0;
    repeat (2) @(negedge clk);
    clearRec();
    rst_n = 1'b1;
    waitIdle(30, "midrst_init");
    expAll();
    checkRet("midrst_init_ret");
    chk("midrst_done_cnt", 32'(doneCnt), 32'd1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
